// File: rtl/vga_sync_gen_pkg.sv
// Shared raster timing constants and phase encoding for the VGA sync generator.
// Latency: n/a (constants only).
// Backpressure: n/a.
package vga_sync_gen_pkg;

    // Counter width; the totals of both axes must fit in it.
    localparam int CNT_W     = 10;
    localparam int CNT_LIMIT = 1 << CNT_W;

    // 640x480@60 defaults.
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam bit DEF_H_POL    = 1'b0;
    localparam bit DEF_V_POL    = 1'b0;

    // Phase of one raster axis.
    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FRONT  = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BACK   = 2'd3
    } phase_e;

    function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_axis_timer.sv
// One raster axis: a wrapping position counter plus its ACTIVE/FRONT/SYNC/BACK phase.
// Latency: count and phase update together on a stepped edge; wrap is combinational from step.
// Backpressure: none; all state holds while step is low.
module vga_axis_timer
    import vga_sync_gen_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step,
    output logic [CNT_W-1:0] count,
    output phase_e           phase,
    output logic             wrap
);

    localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] FRONT_AT = CNT_W'(ACTIVE);
    localparam logic [CNT_W-1:0] SYNC_AT  = CNT_W'(ACTIVE + FP);
    localparam logic [CNT_W-1:0] BACK_AT  = CNT_W'(ACTIVE + FP + SYNC);

    if (TOTAL > CNT_LIMIT) begin : g_total_too_big
        $error("vga_axis_timer: axis total %0d does not fit the position counter", TOTAL);
    end

    logic [CNT_W-1:0] count_q, count_d;
    phase_e           phase_q, phase_d;

    // Next count and phase; the phase moves on the same edge the count reaches a boundary.
    always_comb begin
        count_d = count_q;
        phase_d = phase_q;
        wrap    = 1'b0;
        if (step) begin
            if (count_q == LAST) begin
                count_d = '0;
                wrap    = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
            case (phase_q)
                PH_ACTIVE: if (count_d == FRONT_AT) phase_d = PH_FRONT;
                PH_FRONT:  if (count_d == SYNC_AT)  phase_d = PH_SYNC;
                PH_SYNC:   if (count_d == BACK_AT)  phase_d = PH_BACK;
                PH_BACK:   if (wrap)                phase_d = PH_ACTIVE;
                default:                            phase_d = PH_ACTIVE;
            endcase
        end
    end

    // Position and phase registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            phase_q <= PH_ACTIVE;
        end else begin
            count_q <= count_d;
            phase_q <= phase_d;
        end
    end

    assign count = count_q;
    assign phase = phase_q;

endmodule

// File: rtl/vga_sync_gen.sv
// Raster timing generator: pixel coordinates, display-enable, delayed sync/blank and line/frame strobes.
// Latency: counters/in_display/ticks are current; hsync/vsync/blank_n lag by PIPE_DELAY enabled pixels.
// Backpressure: pix_en low freezes counters, phases and the delay pipeline; ticks are forced low.
module vga_sync_gen
    import vga_sync_gen_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter bit H_POL      = DEF_H_POL,
    parameter bit V_POL      = DEF_V_POL,
    parameter int PIPE_DELAY = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pix_en,
    output logic [CNT_W-1:0] CounterX,
    output logic [CNT_W-1:0] CounterY,
    output logic             in_display,
    output logic             hsync,
    output logic             vsync,
    output logic             blank_n,
    output logic             line_tick,
    output logic             frame_tick
);

    if (PIPE_DELAY < 1 || PIPE_DELAY > 4) begin : g_bad_pipe_delay
        $error("vga_sync_gen: PIPE_DELAY %0d outside 1..4", PIPE_DELAY);
    end

    phase_e h_phase, v_phase;
    logic   h_wrap, v_wrap_unused;
    logic   hs_raw, vs_raw;

    vga_axis_timer #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h_timer (
        .clk   (clk),
        .reset (reset),
        .step  (pix_en),
        .count (CounterX),
        .phase (h_phase),
        .wrap  (h_wrap)
    );

    // The vertical axis only advances when the horizontal axis wraps.
    vga_axis_timer #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v_timer (
        .clk   (clk),
        .reset (reset),
        .step  (pix_en & h_wrap),
        .count (CounterY),
        .phase (v_phase),
        .wrap  (v_wrap_unused)
    );

    // Display window, raw syncs and strobes, all aligned with the current counters.
    always_comb begin
        in_display = ~reset && (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
        hs_raw     = (h_phase == PH_SYNC) ? H_POL : ~H_POL;
        vs_raw     = (v_phase == PH_SYNC) ? V_POL : ~V_POL;
        line_tick  = pix_en && ~reset && (CounterX == '0);
        frame_tick = line_tick && (CounterY == CNT_W'(V_ACTIVE));
    end

    logic [PIPE_DELAY-1:0] hs_pipe_q, hs_pipe_d;
    logic [PIPE_DELAY-1:0] vs_pipe_q, vs_pipe_d;
    logic [PIPE_DELAY-1:0] bl_pipe_q, bl_pipe_d;

    // Shift sync/blank one stage per enabled pixel so they match the colour path latency.
    always_comb begin
        hs_pipe_d = hs_pipe_q;
        vs_pipe_d = vs_pipe_q;
        bl_pipe_d = bl_pipe_q;
        if (pix_en) begin
            hs_pipe_d[0] = hs_raw;
            vs_pipe_d[0] = vs_raw;
            bl_pipe_d[0] = in_display;
            for (int i = 1; i < PIPE_DELAY; i++) begin
                hs_pipe_d[i] = hs_pipe_q[i-1];
                vs_pipe_d[i] = vs_pipe_q[i-1];
                bl_pipe_d[i] = bl_pipe_q[i-1];
            end
        end
    end

    // Delay stages reset to the inactive level so no partial pulse survives a reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hs_pipe_q <= {PIPE_DELAY{~H_POL}};
            vs_pipe_q <= {PIPE_DELAY{~V_POL}};
            bl_pipe_q <= '0;
        end else begin
            hs_pipe_q <= hs_pipe_d;
            vs_pipe_q <= vs_pipe_d;
            bl_pipe_q <= bl_pipe_d;
        end
    end

    assign hsync   = hs_pipe_q[PIPE_DELAY-1];
    assign vsync   = vs_pipe_q[PIPE_DELAY-1];
    assign blank_n = bl_pipe_q[PIPE_DELAY-1];

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default timing with PIPE_DELAY 1 and 3, plus a tiny active-high raster for frame-level behaviour.
// Latency: n/a.
// Backpressure: n/a.
module tb_vga_sync_gen;

    logic clk = 1'b0;
    logic reset;
    logic pix_en;
    always #5 clk = ~clk;

    logic [9:0] cx [3];
    logic [9:0] cy [3];
    logic       disp [3];
    logic       hs [3];
    logic       vs [3];
    logic       bl [3];
    logic       lt [3];
    logic       ft [3];

    vga_sync_gen #(.PIPE_DELAY(1)) dut0 (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .CounterX(cx[0]), .CounterY(cy[0]), .in_display(disp[0]),
        .hsync(hs[0]), .vsync(vs[0]), .blank_n(bl[0]),
        .line_tick(lt[0]), .frame_tick(ft[0])
    );

    vga_sync_gen #(.PIPE_DELAY(3)) dut1 (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .CounterX(cx[1]), .CounterY(cy[1]), .in_display(disp[1]),
        .hsync(hs[1]), .vsync(vs[1]), .blank_n(bl[1]),
        .line_tick(lt[1]), .frame_tick(ft[1])
    );

    vga_sync_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .H_POL(1'b1), .V_POL(1'b1), .PIPE_DELAY(2)
    ) dut2 (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .CounterX(cx[2]), .CounterY(cy[2]), .in_display(disp[2]),
        .hsync(hs[2]), .vsync(vs[2]), .blank_n(bl[2]),
        .line_tick(lt[2]), .frame_tick(ft[2])
    );

    int checks = 0;
    int errors = 0;
    int n      = 0;   // enabled pixel edges since reset release

    typedef struct {
        int x, y, disp, hs, vs, bl, lt, ft;
    } exp_t;

    // Reference: raster position is just the enabled-pixel count folded by the line and frame sizes.
    function automatic exp_t model(input int k, input int cnt, input bit rst, input bit pe);
        exp_t e;
        int ha, hf, hsw, hb, va, vf, vsw, vb, pd, ht, vt, m, xm, ym;
        bit hp, vp;
        case (k)
            0: begin ha = 640; hf = 16; hsw = 96; hb = 48; va = 480; vf = 10; vsw = 2; vb = 33; hp = 0; vp = 0; pd = 1; end
            1: begin ha = 640; hf = 16; hsw = 96; hb = 48; va = 480; vf = 10; vsw = 2; vb = 33; hp = 0; vp = 0; pd = 3; end
            default: begin ha = 8; hf = 2; hsw = 3; hb = 2; va = 6; vf = 2; vsw = 2; vb = 3; hp = 1; vp = 1; pd = 2; end
        endcase
        ht = ha + hf + hsw + hb;
        vt = va + vf + vsw + vb;
        e.x    = cnt % ht;
        e.y    = (cnt / ht) % vt;
        e.disp = (!rst && e.x < ha && e.y < va) ? 1 : 0;
        e.lt   = (pe && !rst && e.x == 0) ? 1 : 0;
        e.ft   = (e.lt == 1 && e.y == va) ? 1 : 0;
        if (cnt >= pd) begin
            m    = cnt - pd;
            xm   = m % ht;
            ym   = (m / ht) % vt;
            e.hs = (xm >= ha + hf && xm < ha + hf + hsw) ? int'(hp) : int'(!hp);
            e.vs = (ym >= va + vf && ym < va + vf + vsw) ? int'(vp) : int'(!vp);
            e.bl = (xm < ha && ym < va) ? 1 : 0;
        end else begin
            e.hs = int'(!hp);
            e.vs = int'(!vp);
            e.bl = 0;
        end
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input int want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s at t=%0t n=%0d: got %0d expected %0d", nm, $time, n, act, want);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            exp_t e;
            e = model(k, n, reset, pix_en);
            chk($sformatf("dut%0d.CounterX", k),   32'(cx[k]),   e.x);
            chk($sformatf("dut%0d.CounterY", k),   32'(cy[k]),   e.y);
            chk($sformatf("dut%0d.in_display", k), 32'(disp[k]), e.disp);
            chk($sformatf("dut%0d.hsync", k),      32'(hs[k]),   e.hs);
            chk($sformatf("dut%0d.vsync", k),      32'(vs[k]),   e.vs);
            chk($sformatf("dut%0d.blank_n", k),    32'(bl[k]),   e.bl);
            chk($sformatf("dut%0d.line_tick", k),  32'(lt[k]),   e.lt);
            chk($sformatf("dut%0d.frame_tick", k), 32'(ft[k]),   e.ft);
        end
    endtask

    // One clock: drive inputs just after the falling edge, check, then advance through the rising edge.
    task automatic tick(input bit pe, input bit rst);
        pix_en = pe;
        reset  = rst;
        if (rst) n = 0;
        #1;
        check_all();
        @(posedge clk);
        if (!reset && pix_en) n++;
        @(negedge clk);
    endtask

    typedef struct {
        int n, x, y, hs1, bl1, disp, hs3, bl3;
    } vec_t;
    vec_t tv [13];

    int lo0, lo1, lo_t, lt_cnt, ft_cnt;

    initial begin
        // {enabled edge, X, Y, hsync d1, blank_n d1, in_display, hsync d3, blank_n d3}
        tv[0]  = '{1,   1,   0, 1, 1, 1, 1, 0};
        tv[1]  = '{3,   3,   0, 1, 1, 1, 1, 1};
        tv[2]  = '{640, 640, 0, 1, 1, 0, 1, 1};
        tv[3]  = '{641, 641, 0, 1, 0, 0, 1, 1};
        tv[4]  = '{643, 643, 0, 1, 0, 0, 1, 0};
        tv[5]  = '{657, 657, 0, 0, 0, 0, 1, 0};
        tv[6]  = '{659, 659, 0, 0, 0, 0, 0, 0};
        tv[7]  = '{752, 752, 0, 0, 0, 0, 0, 0};
        tv[8]  = '{753, 753, 0, 1, 0, 0, 0, 0};
        tv[9]  = '{755, 755, 0, 1, 0, 0, 1, 0};
        tv[10] = '{800, 0,   1, 1, 0, 1, 1, 0};
        tv[11] = '{801, 1,   1, 1, 1, 1, 1, 0};
        tv[12] = '{803, 3,   1, 1, 1, 1, 1, 1};

        reset  = 1'b1;
        pix_en = 1'b0;
        @(negedge clk);

        // Reset held 5 cycles, then released at (0,0).
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b1);
        chk("reset.hsync", 32'(hs[0]), 1);
        chk("reset.vsync", 32'(vs[0]), 1);
        chk("reset.blank_n", 32'(bl[0]), 0);
        chk("reset.tiny_hsync", 32'(hs[2]), 0);

        // Fixed-position vectors along the first two lines.
        for (int i = 0; i < 13; i++) begin
            while (n < tv[i].n) tick(1'b1, 1'b0);
            #1;
            chk($sformatf("tbl%0d.CounterX", i),     32'(cx[0]),   tv[i].x);
            chk($sformatf("tbl%0d.CounterY", i),     32'(cy[0]),   tv[i].y);
            chk($sformatf("tbl%0d.hsync_d1", i),     32'(hs[0]),   tv[i].hs1);
            chk($sformatf("tbl%0d.blank_n_d1", i),   32'(bl[0]),   tv[i].bl1);
            chk($sformatf("tbl%0d.in_display", i),   32'(disp[0]), tv[i].disp);
            chk($sformatf("tbl%0d.hsync_d3", i),     32'(hs[1]),   tv[i].hs3);
            chk($sformatf("tbl%0d.blank_n_d3", i),   32'(bl[1]),   tv[i].bl3);
        end

        // hsync pulse width over the second line, both delays.
        lo0 = 0;
        lo1 = 0;
        while (n < 1600) begin
            if (n >= 800 && hs[0] == 1'b0) lo0++;
            if (n >= 800 && hs[1] == 1'b0) lo1++;
            tick(1'b1, 1'b0);
        end
        chk("hsync_width_d1", 32'(lo0), 96);
        chk("hsync_width_d3", 32'(lo1), 96);

        // Random pixel enable against the reference model.
        for (int i = 0; i < 3000; i++) tick(($urandom_range(0, 3) != 0), 1'b0);

        // Asynchronous reset in the middle of the hsync pulse at X=700.
        while ((n % 800) != 700) tick(1'b1, 1'b0);
        chk("pre_reset.hsync_low", 32'(hs[0]), 0);
        #2;
        reset = 1'b1;
        n     = 0;
        #1;
        check_all();
        chk("async.CounterX", 32'(cx[0]), 0);
        chk("async.hsync", 32'(hs[0]), 1);
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b1);
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b0);
        chk("post_reset.hsync_high", 32'(hs[0]), 1);

        // Half-rate pixel enable: hsync low should span 192 clocks.
        tick(1'b1, 1'b1);
        lo_t = 0;
        for (int i = 0; i < 1800; i++) begin
            if (hs[0] == 1'b0) lo_t++;
            tick((i % 2) == 0, 1'b0);
        end
        chk("hsync_width_half_rate", 32'(lo_t), 192);

        // Three whole frames of the tiny raster: 13 lines and one frame strobe each.
        tick(1'b1, 1'b1);
        lt_cnt = 0;
        ft_cnt = 0;
        pix_en = 1'b1;
        reset  = 1'b0;
        for (int i = 0; i < 585; i++) begin
            #1;
            if (lt[2]) lt_cnt++;
            if (ft[2]) ft_cnt++;
            tick(1'b1, 1'b0);
        end
        chk("tiny.line_ticks", 32'(lt_cnt), 39);
        chk("tiny.frame_ticks", 32'(ft_cnt), 3);
        chk("tiny.wrapped_to_origin", 32'(cy[2]), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
